// File: rtl/lab_buffer_manager.sv
// ============================================================================
// Module  : lab_buffer_manager
// Brief   : Occupancy tracking and in-order digitize sequencing for the four
//           LAB analog buffers. Optional macro: BUFMGR_DROP_CNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lab_buffer_manager #(
    parameter int NBUF        = 4,
    parameter int DIG_TIMEOUT = 4000
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            trig_wr_i,
    input  logic [1:0]      trig_buf_i,
    output logic            dig_start_o,
    output logic [1:0]      dig_buf_o,
    input  logic            dig_done_i,
    output logic            rd_avail_o,
    output logic [1:0]      rd_buf_o,
    input  logic            rd_release_i,
    output logic [NBUF-1:0] occupied_o,
    output logic            busy_o,
    output logic            overflow_o,
    output logic            timeout_o,
    input  logic            clr_err_i,
    output logic [7:0]      drop_cnt_o
);

    localparam int            TW         = (DIG_TIMEOUT > 1) ? $clog2(DIG_TIMEOUT) : 1;
    localparam logic [TW-1:0] c_TMO_LAST = TW'(DIG_TIMEOUT - 1);
    localparam logic [NBUF-1:0] c_ONE    = NBUF'(1);

    typedef enum logic [1:0] {
        DIDLE  = 2'd0,
        DSTART = 2'd1,
        DWAIT  = 2'd2
    } dstate_t;

    dstate_t         r_state;
    logic [1:0]      r_queue [NBUF];
    logic [2:0]      r_wr_ptr;
    logic [2:0]      r_dig_ptr;
    logic [2:0]      r_rd_ptr;
    logic [NBUF-1:0] r_occupied;
    logic            r_dig_start;
    logic [1:0]      r_dig_buf;
    logic [TW-1:0]   r_timer;
    logic            r_overflow;
    logic            r_timeout;

    logic            w_rd_avail;
    logic [1:0]      w_rd_buf;
    logic            w_release;
    logic [NBUF-1:0] w_rel_mask;
    logic [NBUF-1:0] w_occ_after_rel;
    logic            w_trig_ok;
    logic            w_trig_drop;
    logic [NBUF-1:0] w_trig_mask;
    logic            w_done;
    logic            w_tmo;

    assign w_rd_avail = (r_rd_ptr != r_dig_ptr);
    assign w_rd_buf   = r_queue[r_rd_ptr[1:0]];
    assign w_release  = rd_release_i & w_rd_avail;
    assign w_rel_mask = w_release ? (c_ONE << w_rd_buf) : '0;

    // A release in the same cycle frees its buffer before the trigger is judged.
    assign w_occ_after_rel = r_occupied & ~w_rel_mask;
    assign w_trig_ok       = trig_wr_i & ~w_occ_after_rel[trig_buf_i];
    assign w_trig_drop     = trig_wr_i &  w_occ_after_rel[trig_buf_i];
    assign w_trig_mask     = w_trig_ok ? (c_ONE << trig_buf_i) : '0;

    assign w_done = (r_state == DWAIT) & dig_done_i;
    assign w_tmo  = (r_state == DWAIT) & ~dig_done_i & (r_timer == c_TMO_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr   <= 3'd0;
            r_rd_ptr   <= 3'd0;
            r_occupied <= '0;
            r_overflow <= 1'b0;
            for (int i = 0; i < NBUF; i++) begin
                r_queue[i] <= 2'd0;
            end
        end else begin
            if (w_trig_ok) begin
                r_queue[r_wr_ptr[1:0]] <= trig_buf_i;
                r_wr_ptr               <= r_wr_ptr + 3'd1;
            end
            if (w_release) begin
                r_rd_ptr <= r_rd_ptr + 3'd1;
            end
            r_occupied <= w_occ_after_rel | w_trig_mask;
            if (w_trig_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_err_i) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Digitize sequencer; a timed-out buffer is still handed to readout.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= DIDLE;
            r_dig_ptr   <= 3'd0;
            r_dig_start <= 1'b0;
            r_dig_buf   <= 2'd0;
            r_timer     <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_dig_start <= 1'b0;
            case (r_state)
                DIDLE: begin
                    if (r_dig_ptr != r_wr_ptr) begin
                        r_state     <= DSTART;
                        r_dig_start <= 1'b1;
                        r_dig_buf   <= r_queue[r_dig_ptr[1:0]];
                    end
                end
                DSTART: begin
                    r_state <= DWAIT;
                    r_timer <= '0;
                end
                DWAIT: begin
                    if (w_done || w_tmo) begin
                        r_dig_ptr <= r_dig_ptr + 3'd1;
                        r_state   <= DIDLE;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                default: begin
                    r_state <= DIDLE;
                end
            endcase
            if (w_tmo) begin
                r_timeout <= 1'b1;
            end else if (clr_err_i) begin
                r_timeout <= 1'b0;
            end
        end
    end

`ifdef BUFMGR_DROP_CNT_EN
    logic [7:0] r_drop_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_drop_cnt <= 8'd0;
        end else if (w_trig_drop) begin
            if (r_drop_cnt != 8'hFF) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end else if (clr_err_i) begin
            r_drop_cnt <= 8'd0;
        end
    end

    assign drop_cnt_o = r_drop_cnt;
`else
    assign drop_cnt_o = 8'd0;
`endif

    assign dig_start_o = r_dig_start;
    assign dig_buf_o   = r_dig_buf;
    assign rd_avail_o  = w_rd_avail;
    assign rd_buf_o    = w_rd_buf;
    assign occupied_o  = r_occupied;
    assign busy_o      = &r_occupied;
    assign overflow_o  = r_overflow;
    assign timeout_o   = r_timeout;

endmodule

`default_nettype wire
